// File: rtl/mips_pkg.sv
// Shared MIPS constants: datapath width, register count, opcode and funct encodings.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

endpackage

// File: rtl/register_file.sv
// 2-read/1-write register file. Reads are asynchronous with write-through bypass;
// reset loads reg[i] = i, and register 0 is hardwired to zero.
module register_file
  import mips_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int NR = NREG,
  parameter int AW = $clog2(NR)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2
);

  logic [DW-1:0] regs [NR];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NR; i++) regs[i] <= DW'(i);
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Write-through lets the ID stage see the value being written back this cycle.
  function automatic logic [DW-1:0] read_port(input logic [AW-1:0] addr);
    if (addr == '0)                  return '0;
    else if (we && (waddr == addr))  return wdata;
    else                             return regs[addr];
  endfunction

  always_comb begin
    rdata1 = read_port(raddr1);
    rdata2 = read_port(raddr2);
  end

endmodule

// File: rtl/instruction_decode.sv
// MIPS ID stage: field decode, register read, early beq/bne resolution and
// load-use / branch hazard detection. All outputs are combinational.
module instruction_decode
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int NREG   = mips_pkg::NREG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic [31:0]       PCPlus4D,
  input  logic              RegWriteW,
  input  logic [4:0]        WriteRegW,
  input  logic [DATA_W-1:0] ResultW,
  input  logic              RegWriteM,
  input  logic [4:0]        WriteRegM,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic              MemtoRegM,
  input  logic              MemReadE,
  input  logic              RegWriteE,
  input  logic [4:0]        WriteRegE,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  output logic [4:0]        RsD,
  output logic [4:0]        RtD,
  output logic [4:0]        RdD,
  output logic [31:0]       signImmD,
  output logic [31:0]       PCbranchD,
  output logic              hazardDetected,
  output logic              PCSrcD,
  output logic              equalD
);

  logic [5:0]        opcode;
  logic [DATA_W-1:0] cmp_a, cmp_b;
  logic              beq_d, bne_d, branch_d;
  logic              rs_hit_e, rt_hit_e, rs_hit_m, rt_hit_m;
  logic              lwstall, branchstall;

  assign RsD      = instruction[25:21];
  assign RtD      = instruction[20:16];
  assign RdD      = instruction[15:11];
  assign opcode   = instruction[31:26];
  assign signImmD = {{16{instruction[15]}}, instruction[15:0]};

  register_file #(.DW(DATA_W), .NR(NREG), .AW(5)) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (RegWriteW),
    .waddr  (WriteRegW),
    .wdata  (ResultW),
    .raddr1 (RsD),
    .raddr2 (RtD),
    .rdata1 (data1),
    .rdata2 (data2)
  );

  // Only the branch comparator sees the MEM-stage forward; data1/data2 stay raw.
  always_comb begin
    cmp_a = data1;
    cmp_b = data2;
    if (RegWriteM && (WriteRegM == RsD) && (RsD != '0)) cmp_a = ALUOutM;
    if (RegWriteM && (WriteRegM == RtD) && (RtD != '0)) cmp_b = ALUOutM;
  end

  assign equalD    = (cmp_a == cmp_b);
  assign PCbranchD = PCPlus4D + {signImmD[29:0], 2'b00};

  assign beq_d    = (opcode == OP_BEQ);
  assign bne_d    = (opcode == OP_BNE);
  assign branch_d = beq_d | bne_d;

  assign rs_hit_e = (RsD != '0) && (WriteRegE == RsD);
  assign rt_hit_e = (RtD != '0) && (WriteRegE == RtD);
  assign rs_hit_m = (RsD != '0) && (WriteRegM == RsD);
  assign rt_hit_m = (RtD != '0) && (WriteRegM == RtD);

  assign lwstall     = MemReadE && (rs_hit_e || rt_hit_e);
  assign branchstall = branch_d && ((RegWriteE && (rs_hit_e || rt_hit_e)) ||
                                    (MemtoRegM && (rs_hit_m || rt_hit_m)));

  assign hazardDetected = lwstall | branchstall;
  assign PCSrcD = !hazardDetected && ((beq_d && equalD) || (bne_d && !equalD));

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: shadow register model feeds a
// scoreboard of expected outputs, plus directed constant checks.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction, PCPlus4D, ResultW, ALUOutM;
  logic        RegWriteW, RegWriteM, MemtoRegM, MemReadE, RegWriteE;
  logic [4:0]  WriteRegW, WriteRegM, WriteRegE;
  logic [31:0] data1, data2, signImmD, PCbranchD;
  logic [4:0]  RsD, RtD, RdD;
  logic        hazardDetected, PCSrcD, equalD;

  always #5 clk = ~clk;

  instruction_decode dut (
    .clk(clk), .reset(reset), .instruction(instruction), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
    .RegWriteM(RegWriteM), .WriteRegM(WriteRegM), .ALUOutM(ALUOutM),
    .MemtoRegM(MemtoRegM), .MemReadE(MemReadE), .RegWriteE(RegWriteE),
    .WriteRegE(WriteRegE), .data1(data1), .data2(data2), .RsD(RsD), .RtD(RtD),
    .RdD(RdD), .signImmD(signImmD), .PCbranchD(PCbranchD),
    .hazardDetected(hazardDetected), .PCSrcD(PCSrcD), .equalD(equalD)
  );

  typedef struct {
    logic [31:0] d1, d2, imm, pcb;
    logic [4:0]  rs, rt, rd;
    logic        eq, haz, pcs;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model_reg [32];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (RegWriteW && WriteRegW == a) return ResultW;
    return model_reg[a];
  endfunction

  task automatic push_expected();
    exp_t e;
    logic [31:0] ca, cb;
    logic [5:0]  op;
    logic        br, lw, bs;
    e.rs  = instruction[25:21];
    e.rt  = instruction[20:16];
    e.rd  = instruction[15:11];
    op    = instruction[31:26];
    e.imm = {{16{instruction[15]}}, instruction[15:0]};
    e.pcb = PCPlus4D + e.imm * 32'd4;
    e.d1  = mread(e.rs);
    e.d2  = mread(e.rt);
    ca = (RegWriteM && WriteRegM == e.rs && e.rs != 0) ? ALUOutM : e.d1;
    cb = (RegWriteM && WriteRegM == e.rt && e.rt != 0) ? ALUOutM : e.d2;
    e.eq = (ca == cb);
    br = (op == 6'h04) || (op == 6'h05);
    lw = MemReadE && ((e.rs != 0 && WriteRegE == e.rs) || (e.rt != 0 && WriteRegE == e.rt));
    bs = br && ((RegWriteE && ((e.rs != 0 && WriteRegE == e.rs) || (e.rt != 0 && WriteRegE == e.rt))) ||
                (MemtoRegM && ((e.rs != 0 && WriteRegM == e.rs) || (e.rt != 0 && WriteRegM == e.rt))));
    e.haz = lw || bs;
    e.pcs = !e.haz && (((op == 6'h04) && e.eq) || ((op == 6'h05) && !e.eq));
    sbq.push_back(e);
  endtask

  task automatic compare_outputs();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sbq.pop_front();
    chk("data1", data1, e.d1);
    chk("data2", data2, e.d2);
    chk("RsD", {27'd0, RsD}, {27'd0, e.rs});
    chk("RtD", {27'd0, RtD}, {27'd0, e.rt});
    chk("RdD", {27'd0, RdD}, {27'd0, e.rd});
    chk("signImmD", signImmD, e.imm);
    chk("PCbranchD", PCbranchD, e.pcb);
    chk("equalD", {31'd0, equalD}, {31'd0, e.eq});
    chk("hazard", {31'd0, hazardDetected}, {31'd0, e.haz});
    chk("PCSrcD", {31'd0, PCSrcD}, {31'd0, e.pcs});
  endtask

  // Inputs were changed #1 after the last edge; sample mid-cycle.
  task automatic step();
    #2;
    push_expected();
    compare_outputs();
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) model_reg[i] = 32'(i);
    end else if (RegWriteW && WriteRegW != 0) begin
      model_reg[WriteRegW] = ResultW;
    end
    #1;
  endtask

  task automatic clear_ctrl();
    reset = 0; RegWriteW = 0; WriteRegW = 0; ResultW = 0;
    RegWriteM = 0; WriteRegM = 0; ALUOutM = 0; MemtoRegM = 0;
    MemReadE = 0; RegWriteE = 0; WriteRegE = 0;
  endtask

  task automatic do_reset();
    clear_ctrl();
    reset = 1;
    tick();
    reset = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model_reg[i] = 'x;
    clear_ctrl();
    instruction = 32'h0;
    PCPlus4D = 32'h0;
    do_reset();

    // add $1,$2,$3 straight out of reset
    instruction = 32'h00430820;
    step();
    chk("tp_rs", {27'd0, RsD}, 32'd2);
    chk("tp_rt", {27'd0, RtD}, 32'd3);
    chk("tp_rd", {27'd0, RdD}, 32'd1);
    chk("tp_d1", data1, 32'd2);
    chk("tp_d2", data2, 32'd3);
    chk("tp_eq", {31'd0, equalD}, 32'd0);
    chk("tp_haz", {31'd0, hazardDetected}, 32'd0);
    tick();

    RegWriteW = 1; WriteRegW = 5'd2; ResultW = 32'd3;
    step();
    chk("bypass_d1", data1, 32'd3);
    chk("bypass_eq", {31'd0, equalD}, 32'd1);
    tick();
    clear_ctrl();
    step();
    chk("after_wr_d1", data1, 32'd3);
    tick();

    instruction = 32'h00000020;
    RegWriteW = 1; WriteRegW = 5'd0; ResultW = 32'h0000FFFF;
    step();
    chk("r0_bypass", data1, 32'd0);
    tick();
    clear_ctrl();
    step();
    chk("r0_after", data1, 32'd0);
    tick();

    // beq $2,$3,-4 after reset
    do_reset();
    instruction = 32'h1043FFFC; PCPlus4D = 32'h100;
    step();
    chk("beq_imm", signImmD, 32'hFFFFFFFC);
    chk("beq_pcb", PCbranchD, 32'h000000F0);
    chk("beq_ne_pcs", {31'd0, PCSrcD}, 32'd0);
    tick();
    RegWriteW = 1; WriteRegW = 5'd3; ResultW = 32'd2;
    step();
    tick();
    clear_ctrl();
    step();
    chk("beq_eq_pcs", {31'd0, PCSrcD}, 32'd1);
    tick();
    instruction = 32'h1443FFFC;
    step();
    chk("bne_eq_pcs", {31'd0, PCSrcD}, 32'd0);
    tick();

    // load-use
    instruction = 32'h00430820; MemReadE = 1; WriteRegE = 5'd3;
    step();
    chk("lw_haz", {31'd0, hazardDetected}, 32'd1);
    tick();
    WriteRegE = 5'd0;
    step();
    chk("lw_r0_haz", {31'd0, hazardDetected}, 32'd0);
    tick();
    clear_ctrl();

    // branch stall with equal comparands (reg2=2, reg3=2)
    instruction = 32'h1043FFFC; RegWriteE = 1; WriteRegE = 5'd2;
    step();
    chk("bstall_haz", {31'd0, hazardDetected}, 32'd1);
    chk("bstall_eq", {31'd0, equalD}, 32'd1);
    chk("bstall_pcs", {31'd0, PCSrcD}, 32'd0);
    tick();
    clear_ctrl();
    MemtoRegM = 1; WriteRegM = 5'd3;
    step();
    chk("bstall_m_haz", {31'd0, hazardDetected}, 32'd1);
    tick();

    // MEM forward into comparator only
    do_reset();
    instruction = 32'h1043FFFC; RegWriteM = 1; WriteRegM = 5'd2; ALUOutM = 32'd3;
    step();
    chk("fwd_eq", {31'd0, equalD}, 32'd1);
    chk("fwd_pcs", {31'd0, PCSrcD}, 32'd1);
    chk("fwd_d1", data1, 32'd2);
    tick();

    // randomized traffic against the shadow model
    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      case ($urandom_range(0, 3))
        0: op = 6'h04;
        1: op = 6'h05;
        2: op = 6'h23;
        default: op = 6'h00;
      endcase
      reset       = ($urandom_range(0, 39) == 0);
      instruction = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      PCPlus4D    = $urandom;
      RegWriteW   = 1'($urandom);
      WriteRegW   = 5'($urandom_range(0, 7));
      ResultW     = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      RegWriteM   = 1'($urandom);
      WriteRegM   = 5'($urandom_range(0, 7));
      ALUOutM     = 32'($urandom_range(0, 7));
      MemtoRegM   = ($urandom_range(0, 3) == 0);
      MemReadE    = ($urandom_range(0, 3) == 0);
      RegWriteE   = ($urandom_range(0, 2) == 0);
      WriteRegE   = 5'($urandom_range(0, 7));
      step();
      tick();
    end

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
